// File: rtl/dma_copy.sv
// Memory-to-memory word-copy engine: configured over the peripheral register bus,
// it borrows the dmem port through hold/holdACK and raises a sticky irq when done.
module dma_copy #(
   parameter int wide = 32,
   parameter int lenw = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [4:0]      addr,
   input  logic [wide-1:0] dataIn,
   output logic [wide-1:0] rdata,
   output logic            hold,
   input  logic            holdACK,
   output logic [wide-1:0] dm_addr,
   output logic            dm_we,
   output logic [wide-1:0] dm_wdata,
   input  logic [wide-1:0] dm_rdata,
   output logic            busy,
   output logic            irq
);

   localparam logic [4:0] A_SRC  = 5'b11000;
   localparam logic [4:0] A_DST  = 5'b11001;
   localparam logic [4:0] A_LEN  = 5'b11010;
   localparam logic [4:0] A_CTRL = 5'b11011;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_DONE} state_t;

   state_t          state_q;
   logic [wide-1:0] src_q, dst_q, dm_addr_q, dm_wdata_q, src_inc;
   logic [lenw-1:0] len_q, len_d;
   logic            hold_q, dm_we_q, irq_q;
   logic            idle, wr_src, wr_dst, wr_len, start, irq_clr;

   assign idle    = (state_q == S_IDLE);
   assign wr_src  = we && (addr == A_SRC)  && idle;
   assign wr_dst  = we && (addr == A_DST)  && idle;
   assign wr_len  = we && (addr == A_LEN)  && idle;
   assign start   = we && (addr == A_CTRL) && dataIn[0] && idle;
   assign irq_clr = we && (addr == A_CTRL) && dataIn[1];
   assign src_inc = src_q + wide'(4);
   assign len_d   = len_q - lenw'(1);

   always_comb begin
      rdata = '0;
      case (addr)
         A_SRC:   rdata = src_q;
         A_DST:   rdata = dst_q;
         A_LEN:   rdata = {{(wide-lenw){1'b0}}, len_q};
         A_CTRL:  rdata = {{(wide-2){1'b0}}, irq_q, ~idle};
         default: rdata = '0;
      endcase
   end

   // NOTE: every state update here is non-blocking, so a later assignment in this
   // block overrides an earlier one; that is how an irq set beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         hold_q     <= 1'b0;
         dm_addr_q  <= '0;
         dm_we_q    <= 1'b0;
         dm_wdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         if (wr_src) src_q <= {dataIn[wide-1:2], 2'b00};
         if (wr_dst) dst_q <= {dataIn[wide-1:2], 2'b00};
         if (wr_len) len_q <= dataIn[lenw-1:0];
         if (irq_clr || start) irq_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (len_q != '0) begin
                     state_q <= S_REQ;
                     hold_q  <= 1'b1;
                  end else begin
                     irq_q <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (holdACK) begin
                  state_q   <= S_RD;
                  dm_addr_q <= src_q;
               end
            end
            S_RD: begin
               // A withdrawn grant abandons this read untouched and re-requests.
               if (!holdACK) begin
                  state_q <= S_REQ;
               end else begin
                  state_q    <= S_WR;
                  dm_addr_q  <= dst_q;
                  dm_wdata_q <= dm_rdata;
                  dm_we_q    <= 1'b1;
               end
            end
            S_WR: begin
               dm_we_q <= 1'b0;
               src_q   <= src_inc;
               dst_q   <= dst_q + wide'(4);
               len_q   <= len_d;
               if (len_d == '0) begin
                  state_q <= S_DONE;
                  hold_q  <= 1'b0;
               end else begin
                  state_q   <= S_RD;
                  dm_addr_q <= src_inc;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               irq_q   <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign hold     = hold_q;
   assign dm_addr  = dm_addr_q;
   assign dm_we    = dm_we_q;
   assign dm_wdata = dm_wdata_q;
   assign busy     = ~idle;
   assign irq      = irq_q;

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: a word-indexed dmem model, a grant that follows hold
// one register later (granted in the second REQ cycle), and per-scenario checks.
module tb_dma_copy;

   localparam logic [4:0] A_SRC  = 5'b11000;
   localparam logic [4:0] A_DST  = 5'b11001;
   localparam logic [4:0] A_LEN  = 5'b11010;
   localparam logic [4:0] A_CTRL = 5'b11011;

   logic        clk = 1'b0;
   logic        rst, we;
   logic [4:0]  addr;
   logic [31:0] dataIn, rdata;
   logic        hold, holdACK, dm_we, busy, irq;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;

   logic        ack_q = 1'b0;
   logic        ack_en;
   logic [31:0] mem [0:1023];
   int          we_cnt = 0;
   int          hold_cnt = 0;
   logic        pk_en;
   logic [9:0]  pk_idx;
   logic [31:0] pk_data;

   int passed = 0;
   int total  = 0;

   dma_copy #(.wide(32), .lenw(16)) dut (
      .clk(clk), .rst(rst), .we(we), .addr(addr), .dataIn(dataIn), .rdata(rdata),
      .hold(hold), .holdACK(holdACK), .dm_addr(dm_addr), .dm_we(dm_we),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .busy(busy), .irq(irq)
   );

   always #5 clk = ~clk;

   assign holdACK  = ack_q & ack_en;
   assign dm_rdata = mem[dm_addr[11:2]];

   always @(posedge clk) begin
      ack_q <= hold;
      if (dm_we) begin
         mem[dm_addr[11:2]] <= dm_wdata;
         we_cnt <= we_cnt + 1;
      end else if (pk_en) begin
         mem[pk_idx] <= pk_data;
      end
      if (hold) hold_cnt <= hold_cnt + 1;
   end

   task automatic poke(input int idx, input logic [31:0] d);
      @(negedge clk);
      pk_en = 1'b1; pk_idx = idx[9:0]; pk_data = d;
      @(posedge clk); #1;
      pk_en = 1'b0;
   endtask

   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; addr = a; dataIn = d;
      @(negedge clk);
      we = 1'b0; addr = 5'd0; dataIn = '0;
   endtask

   task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
      addr = a; #1;
      d = rdata;
      addr = 5'd0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      total++;
      if (busy !== 1'b0) $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", name, busy, n);
      else passed++;
   endtask

   task automatic test_reset;
      logic [31:0] v;
      rst = 1'b0; we = 1'b0; addr = '0; dataIn = '0; ack_en = 1'b1; pk_en = 1'b0;
      pk_idx = '0; pk_data = '0;
      repeat (3) @(negedge clk);
      total++; if ({hold, busy, irq, dm_we} !== 4'b0) $display("FAIL reset_outs: hold/busy/irq/we=%b want 0000", {hold, busy, irq, dm_we}); else passed++;
      total++; if (dm_addr !== 32'h0 || dm_wdata !== 32'h0) $display("FAIL reset_dm: addr=%h wdata=%h want 0", dm_addr, dm_wdata); else passed++;
      rst = 1'b1;
      @(negedge clk);
      bus_rd(A_SRC, v);  total++; if (v !== 32'h0) $display("FAIL reset_src: got %h want 0", v); else passed++;
      bus_rd(A_DST, v);  total++; if (v !== 32'h0) $display("FAIL reset_dst: got %h want 0", v); else passed++;
      bus_rd(A_LEN, v);  total++; if (v !== 32'h0) $display("FAIL reset_len: got %h want 0", v); else passed++;
      bus_rd(A_CTRL, v); total++; if (v !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", v); else passed++;
   endtask

   task automatic test_basic_copy;
      logic [31:0] v;
      int w0, h0;
      for (int i = 0; i < 4; i++) poke(16 + i, 32'hA000_0000 + i);
      for (int i = 0; i < 4; i++) poke(32 + i, 32'h0);
      bus_wr(A_SRC, 32'h40);
      bus_wr(A_DST, 32'h80);
      bus_wr(A_LEN, 32'd4);
      bus_rd(A_SRC, v); total++; if (v !== 32'h40) $display("FAIL basic_src_rd: got %h want 00000040", v); else passed++;
      w0 = we_cnt; h0 = hold_cnt;
      bus_wr(A_CTRL, 32'd1);
      total++; if (hold !== 1'b1 || busy !== 1'b1) $display("FAIL basic_hold_rise: hold=%b busy=%b want 1 1", hold, busy); else passed++;
      wait_idle("basic");
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem[32 + i] !== 32'hA000_0000 + i) $display("FAIL basic_data%0d: got %h want %h", i, mem[32 + i], 32'hA000_0000 + i);
         else passed++;
      end
      total++; if (we_cnt - w0 !== 4) $display("FAIL basic_we_pulses: got %0d want 4", we_cnt - w0); else passed++;
      total++; if (hold_cnt - h0 !== 10) $display("FAIL basic_hold_cycles: got %0d want 10", hold_cnt - h0); else passed++;
      total++; if (irq !== 1'b1) $display("FAIL basic_irq: got %b want 1", irq); else passed++;
      bus_rd(A_CTRL, v); total++; if (v !== 32'd2) $display("FAIL basic_ctrl_rd: got %h want 2", v); else passed++;
      bus_rd(A_SRC, v);  total++; if (v !== 32'h50) $display("FAIL basic_src_end: got %h want 00000050", v); else passed++;
      bus_rd(A_LEN, v);  total++; if (v !== 32'h0) $display("FAIL basic_len_end: got %h want 0", v); else passed++;
      bus_wr(A_CTRL, 32'd2);
      total++; if (irq !== 1'b0) $display("FAIL basic_irq_clear: got %b want 0", irq); else passed++;
   endtask

   task automatic test_zero_len;
      int h0;
      bus_wr(A_LEN, 32'd0);
      h0 = hold_cnt;
      bus_wr(A_CTRL, 32'd1);
      total++; if (irq !== 1'b1) $display("FAIL zero_irq: got %b want 1", irq); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else passed++;
      repeat (4) @(negedge clk);
      total++; if (hold_cnt - h0 !== 0 || hold !== 1'b0) $display("FAIL zero_hold: cycles=%0d hold=%b want 0 0", hold_cnt - h0, hold); else passed++;
      total++; if (busy !== 1'b0 || irq !== 1'b1) $display("FAIL zero_after: busy=%b irq=%b want 0 1", busy, irq); else passed++;
   endtask

   task automatic test_busy_writes;
      logic [31:0] v;
      for (int i = 0; i < 4; i++) poke(64 + i, 32'h5500_0000 + 32'h11 * i);
      bus_wr(A_SRC, 32'h100);
      bus_wr(A_DST, 32'h180);
      bus_wr(A_LEN, 32'd4);
      bus_wr(A_CTRL, 32'd1);
      total++; if (irq !== 1'b0) $display("FAIL busy_start_clr_irq: got %b want 0", irq); else passed++;
      bus_wr(A_SRC, 32'h200);
      bus_wr(A_LEN, 32'd9);
      bus_wr(A_CTRL, 32'd2);
      total++; if (busy !== 1'b1) $display("FAIL busy_ctrl2_abort: busy=%b want 1", busy); else passed++;
      bus_rd(A_CTRL, v); total++; if (v !== 32'd1) $display("FAIL busy_ctrl_rd: got %h want 1", v); else passed++;
      wait_idle("busy");
      bus_rd(A_SRC, v); total++; if (v !== 32'h110) $display("FAIL busy_src_end: got %h want 00000110", v); else passed++;
      bus_rd(A_DST, v); total++; if (v !== 32'h190) $display("FAIL busy_dst_end: got %h want 00000190", v); else passed++;
      bus_rd(A_LEN, v); total++; if (v !== 32'h0) $display("FAIL busy_len_end: got %h want 0", v); else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem[96 + i] !== 32'h5500_0000 + 32'h11 * i) $display("FAIL busy_data%0d: got %h want %h", i, mem[96 + i], 32'h5500_0000 + 32'h11 * i);
         else passed++;
      end
      total++; if (irq !== 1'b1) $display("FAIL busy_irq_end: got %b want 1", irq); else passed++;
   endtask

   task automatic test_grant_withdrawn;
      int w0, n;
      for (int i = 0; i < 3; i++) poke(80 + i, 32'hC3C3_0000 + i);
      for (int i = 0; i < 3; i++) poke(112 + i, 32'h0);
      bus_wr(A_SRC, 32'h140);
      bus_wr(A_DST, 32'h1C0);
      bus_wr(A_LEN, 32'd3);
      w0 = we_cnt;
      bus_wr(A_CTRL, 32'd1);
      n = 0;
      while (dm_we !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      total++; if (dm_we !== 1'b1) $display("FAIL grant_first_wr: dm_we did not rise within %0d cycles", n); else passed++;
      ack_en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if ({hold, dm_we, busy} !== 3'b101) $display("FAIL grant_stall%0d: hold/we/busy=%b want 101", c, {hold, dm_we, busy});
         else passed++;
      end
      total++; if (we_cnt - w0 !== 1) $display("FAIL grant_stall_writes: got %0d want 1", we_cnt - w0); else passed++;
      ack_en = 1'b1;
      wait_idle("grant");
      total++; if (we_cnt - w0 !== 3) $display("FAIL grant_total_writes: got %0d want 3", we_cnt - w0); else passed++;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (mem[112 + i] !== 32'hC3C3_0000 + i) $display("FAIL grant_data%0d: got %h want %h", i, mem[112 + i], 32'hC3C3_0000 + i);
         else passed++;
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] v;
      int w0, n;
      for (int i = 0; i < 4; i++) poke(192 + i, 32'hB000_0000 + i);
      for (int i = 0; i < 4; i++) poke(224 + i, 32'hDEAD_0000 + i);
      bus_wr(A_SRC, 32'h300);
      bus_wr(A_DST, 32'h380);
      bus_wr(A_LEN, 32'd4);
      w0 = we_cnt;
      bus_wr(A_CTRL, 32'd1);
      n = 0;
      while (!(dm_we === 1'b1 && we_cnt - w0 == 1) && n < 40) begin @(negedge clk); n++; end
      total++; if (dm_we !== 1'b1) $display("FAIL rstmid_second_wr: not reached in %0d cycles", n); else passed++;
      @(posedge clk); #1;
      rst = 1'b0; #1;
      total++; if ({hold, busy, dm_we} !== 3'b000) $display("FAIL rstmid_async: hold/busy/we=%b want 000", {hold, busy, dm_we}); else passed++;
      bus_rd(A_SRC, v); total++; if (v !== 32'h0) $display("FAIL rstmid_src: got %h want 0", v); else passed++;
      bus_rd(A_DST, v); total++; if (v !== 32'h0) $display("FAIL rstmid_dst: got %h want 0", v); else passed++;
      bus_rd(A_LEN, v); total++; if (v !== 32'h0) $display("FAIL rstmid_len: got %h want 0", v); else passed++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if (we_cnt - w0 !== 2) $display("FAIL rstmid_writes: got %0d want 2", we_cnt - w0); else passed++;
      for (int i = 0; i < 4; i++) begin
         v = (i < 2) ? 32'hB000_0000 + i : 32'hDEAD_0000 + i;
         total++;
         if (mem[224 + i] !== v) $display("FAIL rstmid_dst%0d: got %h want %h", i, mem[224 + i], v);
         else passed++;
      end
   endtask

   task automatic test_wrap;
      logic [31:0] v;
      poke(1023, 32'hC0C0_C0C0);
      poke(0, 32'hC1C1_C1C1);
      poke(4, 32'h0);
      poke(5, 32'h0);
      bus_wr(A_SRC, 32'hFFFF_FFFE);
      bus_rd(A_SRC, v); total++; if (v !== 32'hFFFF_FFFC) $display("FAIL wrap_src_align: got %h want fffffffc", v); else passed++;
      bus_wr(A_DST, 32'h13);
      bus_rd(A_DST, v); total++; if (v !== 32'h10) $display("FAIL wrap_dst_align: got %h want 00000010", v); else passed++;
      bus_wr(A_LEN, 32'd2);
      bus_wr(A_CTRL, 32'd1);
      wait_idle("wrap");
      total++; if (mem[4] !== 32'hC0C0_C0C0) $display("FAIL wrap_data0: got %h want c0c0c0c0", mem[4]); else passed++;
      total++; if (mem[5] !== 32'hC1C1_C1C1) $display("FAIL wrap_data1: got %h want c1c1c1c1", mem[5]); else passed++;
      bus_rd(A_SRC, v); total++; if (v !== 32'h4) $display("FAIL wrap_src_end: got %h want 00000004", v); else passed++;
      bus_rd(5'b00011, v); total++; if (v !== 32'h0) $display("FAIL unmapped_rd: got %h want 0", v); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic_copy();
      test_zero_len();
      test_busy_writes();
      test_grant_withdrawn();
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
